// File: rtl/rc4_decrypt_core_pkg.sv
// Shared definitions for the RC4 decrypt chain: FSM state encoding,
// printable-character bounds, default message length and the character
// validity test also used by the message-check FSM.
package rc4_pkg;

  localparam int DEFAULT_MSG_LEN = 32;

  localparam logic [7:0] CHAR_A     = 8'd97;
  localparam logic [7:0] CHAR_Z     = 8'd122;
  localparam logic [7:0] CHAR_SPACE = 8'd32;

  typedef enum logic [4:0] {
    ST_IDLE      = 5'd0,
    ST_INIT      = 5'd1,
    ST_INC_I     = 5'd2,
    ST_WAIT_I1   = 5'd3,
    ST_WAIT_I2   = 5'd4,
    ST_READ_I    = 5'd5,
    ST_WAIT_J1   = 5'd6,
    ST_WAIT_J2   = 5'd7,
    ST_READ_J    = 5'd8,
    ST_SWAP_J    = 5'd9,
    ST_SWAP_I    = 5'd10,
    ST_WAIT_F1   = 5'd11,
    ST_WAIT_F2   = 5'd12,
    ST_WRITE_DEC = 5'd13,
    ST_INC_K     = 5'd14,
    ST_CHECK_K   = 5'd15,
    ST_DONE1     = 5'd16,
    ST_DONE2     = 5'd17
  } rc4_state_t;

  // A decrypted byte is acceptable if it is a lowercase letter or a space.
  function automatic logic is_valid_char(input logic [7:0] c);
    return ((c >= CHAR_A) && (c <= CHAR_Z)) || (c == CHAR_SPACE);
  endfunction

endpackage

// File: rtl/rc4_decrypt_core_if.sv
// Handshake and memory-bus bundle between the RC4 PRGA core and its
// S-RAM, encrypted-message ROM and decrypted-message RAM.
// Optional build macro: RC4_EARLY_ABORT_EN adds the 'invalid' flag.
interface rc4_decrypt_core_if #(
  parameter int ADDR_W = 5
);

  logic              start;
  logic              finished;
  logic [7:0]        s_address;
  logic [7:0]        s_data;
  logic              s_wren;
  logic [7:0]        s_q;
  logic [ADDR_W-1:0] rom_address;
  logic [7:0]        rom_q;
  logic [ADDR_W-1:0] dec_address;
  logic [7:0]        dec_data;
  logic              dec_wren;

`ifdef RC4_EARLY_ABORT_EN
  logic              invalid;

  modport master (
    input  start, s_q, rom_q,
    output finished, s_address, s_data, s_wren, rom_address,
           dec_address, dec_data, dec_wren, invalid
  );

  modport slave (
    output start, s_q, rom_q,
    input  finished, s_address, s_data, s_wren, rom_address,
           dec_address, dec_data, dec_wren, invalid
  );
`else
  modport master (
    input  start, s_q, rom_q,
    output finished, s_address, s_data, s_wren, rom_address,
           dec_address, dec_data, dec_wren
  );

  modport slave (
    output start, s_q, rom_q,
    input  finished, s_address, s_data, s_wren, rom_address,
           dec_address, dec_data, dec_wren
  );
`endif

endinterface

// File: rtl/rc4_decrypt_core.sv
// RC4 PRGA stage: walks the key-scheduled S array, produces one keystream
// byte per message byte and writes ROM XOR keystream into the decrypted RAM.
// Every memory read is preceded by two wait states with a stable address.
// Optional build macro: RC4_EARLY_ABORT_EN stops the run at the first byte
// that is not a lowercase letter or space and raises 'invalid'.
module rc4_decrypt_core
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = DEFAULT_MSG_LEN,
  parameter int ADDR_W  = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  rc4_decrypt_core_if.master   bus
);

  // k is 9 bits so that a 256-byte message can reach its terminal count.
  localparam logic [8:0] K_END = 9'(MSG_LEN);

  rc4_state_t r_state;
  logic [7:0] r_i;
  logic [7:0] r_j;
  logic [8:0] r_k;
  logic [7:0] r_si;
  logic [7:0] r_sj;

  logic [7:0]        w_fsum;
  logic [7:0]        w_dec_byte;
  logic              w_finished;
  logic [7:0]        w_s_address;
  logic [7:0]        w_s_data;
  logic              w_s_wren;
  logic [ADDR_W-1:0] w_dec_address;
  logic [7:0]        w_dec_data;
  logic              w_dec_wren;

  assign w_fsum     = r_si + r_sj;
  assign w_dec_byte = bus.s_q ^ bus.rom_q;

`ifdef RC4_EARLY_ABORT_EN
  logic r_invalid;
  assign bus.invalid = r_invalid;
`endif

  // Sequencer and datapath registers: one state per memory step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_i       <= 8'd0;
      r_j       <= 8'd0;
      r_k       <= 9'd0;
      r_si      <= 8'd0;
      r_sj      <= 8'd0;
`ifdef RC4_EARLY_ABORT_EN
      r_invalid <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state <= ST_INIT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_INIT: begin
          r_i       <= 8'd0;
          r_j       <= 8'd0;
          r_k       <= 9'd0;
`ifdef RC4_EARLY_ABORT_EN
          r_invalid <= 1'b0;
`endif
          r_state   <= ST_INC_I;
        end
        ST_INC_I: begin
          r_i     <= r_i + 8'd1;
          r_state <= ST_WAIT_I1;
        end
        ST_WAIT_I1: r_state <= ST_WAIT_I2;
        ST_WAIT_I2: r_state <= ST_READ_I;
        ST_READ_I: begin
          r_si    <= bus.s_q;
          r_j     <= r_j + bus.s_q;
          r_state <= ST_WAIT_J1;
        end
        ST_WAIT_J1: r_state <= ST_WAIT_J2;
        ST_WAIT_J2: r_state <= ST_READ_J;
        ST_READ_J: begin
          r_sj    <= bus.s_q;
          r_state <= ST_SWAP_J;
        end
        ST_SWAP_J:  r_state <= ST_SWAP_I;
        ST_SWAP_I:  r_state <= ST_WAIT_F1;
        ST_WAIT_F1: r_state <= ST_WAIT_F2;
        ST_WAIT_F2: r_state <= ST_WRITE_DEC;
        ST_WRITE_DEC: begin
`ifdef RC4_EARLY_ABORT_EN
          if (!is_valid_char(w_dec_byte)) begin
            r_invalid <= 1'b1;
            r_state   <= ST_DONE1;
          end else begin
            r_state   <= ST_INC_K;
          end
`else
          r_state <= ST_INC_K;
`endif
        end
        ST_INC_K: begin
          r_k     <= r_k + 9'd1;
          r_state <= ST_CHECK_K;
        end
        ST_CHECK_K: begin
          if (r_k == K_END) begin
            r_state <= ST_DONE1;
          end else begin
            r_state <= ST_INC_I;
          end
        end
        ST_DONE1: r_state <= ST_DONE2;
        ST_DONE2: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Memory-side strobes decoded from the current state; addresses stay
  // valid through the read state so the sampled data matches the address.
  always_comb begin
    w_finished    = 1'b0;
    w_s_address   = 8'd0;
    w_s_data      = 8'd0;
    w_s_wren      = 1'b0;
    w_dec_address = '0;
    w_dec_data    = 8'd0;
    w_dec_wren    = 1'b0;
    case (r_state)
      ST_WAIT_I1, ST_WAIT_I2, ST_READ_I: begin
        w_s_address = r_i;
      end
      ST_WAIT_J1, ST_WAIT_J2, ST_READ_J: begin
        w_s_address = r_j;
      end
      ST_SWAP_J: begin
        w_s_address = r_j;
        w_s_data    = r_si;
        w_s_wren    = 1'b1;
      end
      ST_SWAP_I: begin
        w_s_address = r_i;
        w_s_data    = r_sj;
        w_s_wren    = 1'b1;
      end
      ST_WAIT_F1, ST_WAIT_F2: begin
        w_s_address = w_fsum;
      end
      ST_WRITE_DEC: begin
        w_s_address   = w_fsum;
        w_dec_address = r_k[ADDR_W-1:0];
        w_dec_data    = w_dec_byte;
        w_dec_wren    = 1'b1;
      end
      ST_DONE1, ST_DONE2: begin
        w_finished = 1'b1;
      end
      default: begin
        w_finished = 1'b0;
      end
    endcase
  end

  assign bus.finished    = w_finished;
  assign bus.s_address   = w_s_address;
  assign bus.s_data      = w_s_data;
  assign bus.s_wren      = w_s_wren;
  assign bus.rom_address = r_k[ADDR_W-1:0];
  assign bus.dec_address = w_dec_address;
  assign bus.dec_data    = w_dec_data;
  assign bus.dec_wren    = w_dec_wren;

endmodule

// File: tb/tb_rc4_decrypt_core.sv
// Self-checking bench for rc4_decrypt_core: memories with a two-cycle read
// pipeline, a software RC4 model (KSA + PRGA) and directed scenarios with
// random plaintext.
module tb_rc4_decrypt_core;

  localparam int MSG_LEN = 32;
  localparam int ADDR_W  = 5;
  localparam int RUN_CYC = 2 + 14 * MSG_LEN + 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  rc4_decrypt_core_if #(.ADDR_W(ADDR_W)) bus ();

  rc4_decrypt_core #(.MSG_LEN(MSG_LEN), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]        sram    [256];
  logic [7:0]        init_s  [256];
  logic [7:0]        snap_s  [256];
  logic [7:0]        rom     [2**ADDR_W];
  logic [7:0]        dec_mem [MSG_LEN];
  logic              tb_load = 1'b0;
  logic [7:0]        s_a1, s_a2;
  logic [ADDR_W-1:0] r_a1, r_a2;

  int         m_s    [256];
  logic [7:0] exp_ks [256];

  // Memories: writes on the clock edge, reads see the address from two edges ago.
  always @(posedge clk) begin
    if (tb_load) begin
      for (int x = 0; x < 256; x++) sram[x] <= init_s[x];
      for (int x = 0; x < MSG_LEN; x++) dec_mem[x] <= 8'h00;
    end else begin
      if (bus.s_wren) sram[bus.s_address] <= bus.s_data;
      if (bus.dec_wren) dec_mem[bus.dec_address] <= bus.dec_data;
    end
    s_a1 <= bus.s_address;
    s_a2 <= s_a1;
    r_a1 <= bus.rom_address;
    r_a2 <= r_a1;
  end

  assign bus.s_q   = sram[s_a2];
  assign bus.rom_q = rom[r_a2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Software RC4 keystream generation on m_s.
  task automatic model_prga(input int n);
    int i = 0;
    int j = 0;
    int t;
    for (int k = 0; k < n; k++) begin
      i = (i + 1) % 256;
      j = (j + m_s[i]) % 256;
      t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
      exp_ks[k] = 8'(m_s[(m_s[i] + m_s[j]) % 256]);
    end
  endtask

  // kind 0: identity S; kind 1: KSA of key 00 00 01; kind 2: random perm with S[1]=1.
  task automatic setup(input int kind);
    int key [3];
    int j;
    int t;
    int r;
    int v;
    key[0] = 0; key[1] = 0; key[2] = 1;
    for (int x = 0; x < 256; x++) m_s[x] = x;
    if (kind == 1) begin
      j = 0;
      for (int x = 0; x < 256; x++) begin
        j = (j + m_s[x] + key[x % 3]) % 256;
        t = m_s[x]; m_s[x] = m_s[j]; m_s[j] = t;
      end
    end else if (kind == 2) begin
      for (int x = 255; x > 0; x--) begin
        r = int'($urandom_range(0, x));
        t = m_s[x]; m_s[x] = m_s[r]; m_s[r] = t;
      end
      for (int x = 0; x < 256; x++) begin
        if (m_s[x] == 1) begin
          m_s[x] = m_s[1];
          m_s[1] = 1;
        end
      end
    end
    for (int x = 0; x < 256; x++) init_s[x] = 8'(m_s[x]);
    model_prga(MSG_LEN);
    for (int k = 0; k < MSG_LEN; k++) begin
      v = int'($urandom_range(0, 26));
      rom[k] = ((v == 26) ? 8'd32 : 8'(97 + v)) ^ exp_ks[k];
    end
    @(negedge clk); tb_load = 1'b1;
    @(negedge clk); tb_load = 1'b0;
  endtask

  task automatic run_core(input int pulse_at, input int reset_at, input int snap_at,
                          output int lat, output int fin_cnt, output int dw_cnt,
                          output int sw_cnt);
    bit seen_fin = 1'b0;
    bit done = 1'b0;
    lat = 0; fin_cnt = 0; dw_cnt = 0; sw_cnt = 0;
    @(negedge clk); bus.start = 1'b1;
    while (!done && lat < 4 * RUN_CYC) begin
      @(posedge clk); #1;
      lat++;
      bus.start = 1'b0;
      if (bus.finished) begin
        fin_cnt++;
        seen_fin = 1'b1;
      end else if (seen_fin) begin
        done = 1'b1;
      end
      if (bus.s_wren) sw_cnt++;
      if (bus.dec_wren) begin
        dw_cnt++;
        if (int'(bus.dec_address) == snap_at)
          for (int x = 0; x < 256; x++) snap_s[x] = sram[x];
        if (int'(bus.dec_address) == pulse_at) bus.start = 1'b1;
        if (int'(bus.dec_address) == reset_at) begin
          reset_n = 1'b0;
          done = 1'b1;
        end
      end
    end
    chk("run_terminated", 32'(done), 32'd1);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_finished"},    32'(bus.finished),    32'd0);
    chk({tag, "_s_wren"},      32'(bus.s_wren),      32'd0);
    chk({tag, "_dec_wren"},    32'(bus.dec_wren),    32'd0);
    chk({tag, "_s_address"},   32'(bus.s_address),   32'd0);
    chk({tag, "_s_data"},      32'(bus.s_data),      32'd0);
    chk({tag, "_dec_address"}, 32'(bus.dec_address), 32'd0);
    chk({tag, "_dec_data"},    32'(bus.dec_data),    32'd0);
    chk({tag, "_rom_address"}, 32'(bus.rom_address), 32'd0);
  endtask

  task automatic chk_full(input string tag, input int lat, input int fin, input int dw, input int sw);
    chk({tag, "_latency"},  32'(lat), 32'(RUN_CYC));
    chk({tag, "_fin_cyc"},  32'(fin), 32'd2);
    chk({tag, "_dec_wren"}, 32'(dw),  32'(MSG_LEN));
    chk({tag, "_s_wren"},   32'(sw),  32'(2 * MSG_LEN));
    for (int k = 0; k < MSG_LEN; k++)
      chk($sformatf("%s_dec%0d", tag, k), 32'(dec_mem[k]), 32'(rom[k] ^ exp_ks[k]));
    for (int x = 0; x < 256; x++)
      chk($sformatf("%s_s%0d", tag, x), 32'(sram[x]), 32'(m_s[x]));
  endtask

  int lat, fin, dw, sw;

  initial begin
    bus.start = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset");
    @(negedge clk); reset_n = 1'b1;

    // Identity S with the two known ciphertext bytes.
    setup(0);
    rom[0] = 8'h63; rom[1] = 8'h64;
    run_core(-1, -1, 1, lat, fin, dw, sw);
    chk("ident_dec0", 32'(dec_mem[0]), 32'h61);
    chk("ident_dec1", 32'(dec_mem[1]), 32'h61);
    chk("ident_s2_after_b1", 32'(snap_s[2]), 32'd3);
    chk("ident_s3_after_b1", 32'(snap_s[3]), 32'd2);
    chk_full("ident", lat, fin, dw, sw);

    // Full run with S from the key schedule of 24'h000001.
    setup(1);
    run_core(-1, -1, -1, lat, fin, dw, sw);
    chk_full("ksa", lat, fin, dw, sw);

    // start pulsed while busy at byte 10 must be ignored.
    setup(1);
    run_core(10, -1, -1, lat, fin, dw, sw);
    chk_full("busy_start", lat, fin, dw, sw);

    // Reset in the middle of byte 5, then a clean run.
    setup(1);
    run_core(-1, 5, -1, lat, fin, dw, sw);
    #1;
    chk_quiet("midreset");
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    chk_quiet("after_reset_idle");
    setup(1);
    run_core(-1, -1, -1, lat, fin, dw, sw);
    chk_full("rerun", lat, fin, dw, sw);

    // i == j on the first byte: S[1] keeps its value.
    setup(2);
    run_core(-1, -1, 0, lat, fin, dw, sw);
    chk("ieqj_s1", 32'(snap_s[1]), 32'd1);
    chk_full("ieqj", lat, fin, dw, sw);

`ifdef RC4_EARLY_ABORT_EN
    chk("valid_run_invalid", 32'(bus.invalid), 32'd0);
    setup(0);
    rom[3] = 8'h41 ^ exp_ks[3];
    run_core(-1, -1, -1, lat, fin, dw, sw);
    chk("abort_dec3", 32'(dec_mem[3]), 32'h41);
    chk("abort_dec_writes", 32'(dw), 32'd4);
    chk("abort_fin_cyc", 32'(fin), 32'd2);
    chk("abort_latency", 32'(lat), 32'(2 + 14 * 3 + 12 + 2));
    chk("abort_invalid", 32'(bus.invalid), 32'd1);
    for (int k = 0; k < 3; k++)
      chk($sformatf("abort_dec%0d", k), 32'(dec_mem[k]), 32'(rom[k] ^ exp_ks[k]));
    setup(0);
    run_core(-1, -1, -1, lat, fin, dw, sw);
    chk("clear_invalid", 32'(bus.invalid), 32'd0);
    chk_full("after_abort", lat, fin, dw, sw);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
